shader_frame_server: RTL
========================

# shader_frame_server

Memory responder on the GPU instruction-fetch interface. Holds a 1024 × 16-bit shader/frame image and answers every `input_addr` presented by `gpu` with the stored word on `data_input` one cycle later. A byte-stream loader writes new frames into the image at run time and zero-fills the unused tail. While a load is in progress, `gpu_hold` keeps the core parked.

## Interface
- `DATA_DEPTH`, 1024: number of 16-bit words in the image.
- `ADDR_W`, 20: width of the fetch address from `gpu`.
- `DATA_W`, 16: word width.

- `clk`  in  1: single clock; all state is updated on its rising edge.
- `KEY0`  in  1: asynchronous, active-low reset.
- `input_addr`  in  ADDR_W: fetch address driven by `gpu`.
- `data_input`  out  DATA_W: registered fetch data returned to `gpu`.
- `ld_start`  in  1: one-cycle pulse that begins a load.
- `ld_len`  in  11: number of words to load, valid range 1..1024; sampled when `ld_start` is accepted.
- `ld_byte`  in  8: loader data byte.
- `ld_valid`  in  1: `ld_byte` is valid.
- `ld_ready`  out  1: server accepts the current byte.
- `ld_busy`  out  1: a load or fill is in progress.
- `ld_done`  out  1: one-cycle pulse when the image is complete.
- `ld_err`  out  1: sticky; set by a rejected `ld_start`, cleared by the next accepted `ld_start`.
- `gpu_hold`  out  1: equals `ld_busy`; holds `gpu` in reset.

## Operation
- States: IDLE, LOAD_HI, LOAD_LO, FILL, DONE.
- IDLE:
  - `ld_start` with 1 ≤ `ld_len` ≤ 1024: latch `len`, set `wr_ptr` to 0, clear `ld_err`, go to LOAD_HI.
  - `ld_start` with `ld_len` of 0 or greater than 1024: set `ld_err`, stay in IDLE.
- LOAD_HI: a byte is accepted when `ld_valid` && `ld_ready`. Latch it as bits [15:8], go to LOAD_LO.
- LOAD_LO: on an accepted byte, write {hi, byte} to `mem[wr_ptr]` and increment `wr_ptr`.
  - If the new `wr_ptr` equals `len`: go to FILL when `len` < DATA_DEPTH, otherwise go to DONE.
  - Otherwise go back to LOAD_HI.
- FILL: write 0 to `mem[wr_ptr]` each cycle and increment `wr_ptr`. After writing DATA_DEPTH−1, go to DONE.
- DONE: `ld_done` is high for this one cycle, then go to IDLE.
- `ld_start` is ignored outside IDLE.
- Read path, every cycle:
  - `data_input` ← `mem[input_addr]` when `input_addr` < DATA_DEPTH, otherwise 0.
  - When `ld_busy` is high, `data_input` is forced to 0 (NOP).
- Same-address read and write in one cycle: read-first, so the old word is returned.
- `ld_ready` = 1 exactly in LOAD_HI and LOAD_LO.
- `ld_busy` = 1 in LOAD_HI, LOAD_LO and FILL.

## Timing
- Reset (`KEY0` = 0), asynchronous:
  - state = IDLE.
  - `data_input` = 0, `ld_ready` = 0, `ld_busy` = 0, `gpu_hold` = 0, `ld_done` = 0, `ld_err` = 0, `wr_ptr` = 0.
  - Memory contents are not reset.
- Reset during a load aborts it. Words already written are kept; the tail is not filled.
- Fetch latency is one cycle: the address presented at edge n has its data valid after edge n+1, with no stall or handshake.
- Load of N words with back-to-back valid bytes:
  - 1 cycle for start, 2N cycles for bytes, DATA_DEPTH−N cycles for fill.
  - `ld_done` then asserts in the following cycle.
  - Written words are visible to fetches from the cycle after `ld_done`.
- `ld_valid` gaps stall the loader without limit; there is no timeout.
- `ld_busy` falls in the same cycle that `ld_done` rises.

## Structure
- Shared package `gpu_mem_pkg`:
  - `DATA_DEPTH`, `DATA_W`, `ADDR_W`.
  - Loader state enum `ld_state_t`.
  - `NOP_WORD` = 16'h0000.
- One sub-module, `frame_ram`: simple dual-port RAM with one write port and one registered read port, read-first, DATA_DEPTH × DATA_W, no reset.
- The FSM, address-range check and NOP forcing live in `shader_frame_server`.

## Test plan
- Reset, then fetch `input_addr` = 5: `data_input` = 0 and all control outputs are 0.
- `ld_start` with `ld_len` = 3, bytes 12 34 AB CD 00 07 back-to-back:
  - `mem[0..2]` = 1234, ABCD, 0007 and `mem[3..1023]` = 0.
  - `ld_done` pulses exactly 2·3 + 1021 + 1 cycles after start.
  - `gpu_hold` is high throughout.
- After that load, fetch addresses 1, 2, 3 and 20'h00400 on consecutive cycles: returns ABCD, 0007, 0000, 0000, each one cycle after its address.
- `ld_len` = 0 and then `ld_len` = 1025: `ld_err` sets, state stays IDLE. A following valid `ld_start` clears `ld_err`.
- `ld_len` = 1024 with `ld_valid` toggling every other cycle:
  - `ld_ready` honoured on every byte, no FILL cycles.
  - `mem[1023]` holds the last word.
  - `ld_start` asserted mid-load is ignored.
- Assert `KEY0` low in LOAD_LO after 2 words of a 4-word load:
  - Outputs drop immediately, `mem[0..1]` keep the new words, `mem[2..]` keep their old contents.
  - A fresh load afterwards completes normally.

Source files
------------

// File: rtl/gpu_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpu_mem_pkg
// Description : Shared constants, loader state encoding and helpers for the
//               shader/frame image server and its GPU-side interface.
// Revision    : 1.0 - initial release
// ============================================================================
package gpu_mem_pkg;

  localparam int DATA_DEPTH = 1024;
  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 20;
  localparam int RAM_AW     = $clog2(DATA_DEPTH);

  // Word returned to the GPU while the image is being rewritten.
  localparam logic [DATA_W-1:0] NOP_WORD = 16'h0000;

  typedef enum logic [2:0] {
    LD_IDLE = 3'd0,
    LD_HI   = 3'd1,
    LD_LO   = 3'd2,
    LD_FILL = 3'd3,
    LD_DONE = 3'd4
  } ld_state_t;

  // True when a fetch address falls inside the stored image.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return addr < ADDR_W'(DATA_DEPTH);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shader_frame_server_if.sv
`default_nettype none
// ============================================================================
// Module      : shader_frame_server_if
// Description : GPU fetch bus plus byte-stream loader handshake.
//               master : GPU core / loader side (drives address and bytes)
//               slave  : shader_frame_server (returns data and status)
//   input_addr  fetch address            data_input  registered fetch word
//   ld_start    load start pulse         ld_len      word count 1..1024
//   ld_byte     loader byte              ld_valid    byte valid
//   ld_ready    byte accepted            ld_busy     load/fill in progress
//   ld_done     image complete pulse     ld_err      sticky bad-start flag
//   gpu_hold    keeps the core parked during a load
// Revision    : 1.0 - initial release
// ============================================================================
interface shader_frame_server_if;
  import gpu_mem_pkg::*;

  logic [ADDR_W-1:0] input_addr;
  logic [DATA_W-1:0] data_input;
  logic              ld_start;
  logic [10:0]       ld_len;
  logic [7:0]        ld_byte;
  logic              ld_valid;
  logic              ld_ready;
  logic              ld_busy;
  logic              ld_done;
  logic              ld_err;
  logic              gpu_hold;

  modport master (
    output input_addr, ld_start, ld_len, ld_byte, ld_valid,
    input  data_input, ld_ready, ld_busy, ld_done, ld_err, gpu_hold
  );

  modport slave (
    input  input_addr, ld_start, ld_len, ld_byte, ld_valid,
    output data_input, ld_ready, ld_busy, ld_done, ld_err, gpu_hold
  );

endinterface
`default_nettype wire

// File: rtl/frame_ram.sv
`default_nettype none
// ============================================================================
// Module      : frame_ram
// Description : Simple dual-port RAM, one write port and one registered
//               read port, read-first on address collision, no reset.
//   clk    clock            we     write enable
//   waddr  write address    wdata  write data
//   raddr  read address     rdata  registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module frame_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Both updates are non-blocking, so a same-address read sees the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/shader_frame_server.sv
`default_nettype none
// ============================================================================
// Module      : shader_frame_server
// Description : Memory responder for the GPU instruction-fetch bus. Serves a
//               1024 x 16 image with one-cycle fetch latency and accepts
//               new frames from a byte-stream loader (high byte first),
//               zero-filling the unused tail of the image.
//   clk   clock
//   KEY0  asynchronous active-low reset
//   bus   shader_frame_server_if.slave (fetch bus + loader handshake)
// Revision    : 1.0 - initial release
// ============================================================================
module shader_frame_server
  import gpu_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  KEY0,
  shader_frame_server_if.slave  bus
);

  localparam logic [2:0] ST_IDLE = LD_IDLE;
  localparam logic [2:0] ST_HI   = LD_HI;
  localparam logic [2:0] ST_LO   = LD_LO;
  localparam logic [2:0] ST_FILL = LD_FILL;
  localparam logic [2:0] ST_DONE = LD_DONE;

  localparam logic [10:0] DEPTH_CNT = 11'(DATA_DEPTH);
  localparam logic [10:0] LAST_IDX  = 11'(DATA_DEPTH - 1);

  logic [2:0]        state;
  logic [10:0]       len;
  logic [10:0]       wr_ptr;
  logic [7:0]        hi_byte;
  logic              err_q;
  logic              rd_ok;

  logic              ready;
  logic              busy;
  logic              accept;
  logic              start_ok;
  logic              we;
  logic [10:0]       wr_ptr_inc;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  assign ready      = (state == ST_HI) || (state == ST_LO);
  assign busy       = ready || (state == ST_FILL);
  assign accept     = bus.ld_valid && ready;
  assign start_ok   = (bus.ld_len != 11'd0) && (bus.ld_len <= DEPTH_CNT);
  assign wr_ptr_inc = wr_ptr + 11'd1;

  // Writes happen on the low byte of each word and on every fill cycle.
  assign we    = ((state == ST_LO) && accept) || (state == ST_FILL);
  assign wdata = (state == ST_FILL) ? NOP_WORD : {hi_byte, bus.ld_byte};

  always_ff @(posedge clk or negedge KEY0) begin
    if (!KEY0) begin
      state   <= ST_IDLE;
      len     <= 11'd0;
      wr_ptr  <= 11'd0;
      hi_byte <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.ld_start) begin
            if (start_ok) begin
              len    <= bus.ld_len;
              wr_ptr <= 11'd0;
              err_q  <= 1'b0;
              state  <= ST_HI;
            end else begin
              err_q  <= 1'b1;
            end
          end
        end
        ST_HI: begin
          if (accept) begin
            hi_byte <= bus.ld_byte;
            state   <= ST_LO;
          end
        end
        ST_LO: begin
          if (accept) begin
            wr_ptr <= wr_ptr_inc;
            if (wr_ptr_inc == len) begin
              // A full-depth image leaves no tail to clear.
              state <= (len < DEPTH_CNT) ? ST_FILL : ST_DONE;
            end else begin
              state <= ST_HI;
            end
          end
        end
        ST_FILL: begin
          wr_ptr <= wr_ptr_inc;
          if (wr_ptr == LAST_IDX) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // The RAM output has no reset, so an in-range flag registered alongside it
  // gates the returned word; this also gives zero for out-of-image fetches.
  always_ff @(posedge clk or negedge KEY0) begin
    if (!KEY0) begin
      rd_ok <= 1'b0;
    end else begin
      rd_ok <= addr_in_range(bus.input_addr);
    end
  end

  frame_ram #(
    .DEPTH (DATA_DEPTH),
    .WIDTH (DATA_W),
    .AW    (RAM_AW)
  ) u_frame_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr[RAM_AW-1:0]),
    .wdata (wdata),
    .raddr (bus.input_addr[RAM_AW-1:0]),
    .rdata (rdata)
  );

  // While the image is being rewritten the core only ever sees NOPs.
  assign bus.data_input = (rd_ok && !busy) ? rdata : NOP_WORD;
  assign bus.ld_ready   = ready;
  assign bus.ld_busy    = busy;
  assign bus.gpu_hold   = busy;
  assign bus.ld_done    = (state == ST_DONE);
  assign bus.ld_err     = err_q;

endmodule
`default_nettype wire
